saddr_issue_sched: RTL and testbench

//  Issue scheduler in front of the store-address calculator. Three sources share its single issue

---
 rtl/saddr_sched_pkg.sv | 20 ++
 rtl/saddr_issue_sched_if.sv | 29 ++
 rtl/saddr_replay_fifo.sv | 57 +++++
 rtl/saddr_issue_sched.sv | 157 +++++++++++++++
 tb/tb_saddr_issue_sched.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/saddr_sched_pkg.sv
// Shared types for the store-address issue scheduler: FSM states and replay entries.
// Tag width and retry limit live here so the replay entry struct and every user agree.
package saddr_sched_pkg;

    localparam int unsigned TAG_W     = 9;
    localparam int unsigned MAX_RETRY = 3;
    localparam int unsigned RETRY_W   = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        WAIT   = 2'd1,
        REPLAY = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [RETRY_W-1:0] retry_cnt;
    } replay_ent_t;

endpackage

// File: rtl/saddr_issue_sched_if.sv
// Issue-slot bus between the pipeline/miss handler and the store-address issue scheduler.
interface saddr_issue_sched_if;
    import saddr_sched_pkg::*;

    logic             except;
    logic             new_vld;
    logic [TAG_W-1:0] new_tag;
    logic             new_rdy;
    logic             mex_req;
    logic             mex_gnt;
    logic             miss_vld;
    logic             fill_done;
    logic             iss_en;
    logic [TAG_W-1:0] iss_tag;
    logic             iss_replay;
    logic             flt_vld;
    logic [TAG_W-1:0] flt_tag;

    modport master (
        output except, new_vld, new_tag, mex_req, miss_vld, fill_done,
        input  new_rdy, mex_gnt, iss_en, iss_tag, iss_replay, flt_vld, flt_tag
    );

    modport slave (
        input  except, new_vld, new_tag, mex_req, miss_vld, fill_done,
        output new_rdy, mex_gnt, iss_en, iss_tag, iss_replay, flt_vld, flt_tag
    );

endinterface

// File: rtl/saddr_replay_fifo.sv
// Circular buffer of ops awaiting replay after an MLB miss; flush empties it in one cycle.
module saddr_replay_fifo
    import saddr_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  replay_ent_t              push_ent_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output replay_ent_t              head_o,
    output logic                     empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

    replay_ent_t     mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            do_pop;

    assign do_pop  = pop_i & (count_q != '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap on overflow.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push_i && !do_pop) begin
                count_q <= count_q + (PtrW + 1)'(1);
            end else if (!push_i && do_pop) begin
                count_q <= count_q - (PtrW + 1)'(1);
            end
        end
    end

    // Entry storage; no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_ent_i;
    end

    // The scheduler reserves a slot for the in-flight op, so a push never meets a full buffer.
    assert property (@(posedge clk) disable iff (rst || flush_i)
                     !(push_i && !do_pop && count_q == FullCnt));

endmodule

// File: rtl/saddr_issue_sched.sv
// Store-address issue scheduler: arbitrates mex probes, replays and new ops onto one issue slot,
// tracks MLB misses in a replay FIFO and faults ops that exceed the retry limit.
// Optional macro SADDR_SCHED_PERF_EN adds miss/stall performance counters.
module saddr_issue_sched
    import saddr_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    saddr_issue_sched_if.slave bus_io
`ifdef SADDR_SCHED_PERF_EN
    ,
    output logic [31:0]        perf_miss_o,
    output logic [31:0]        perf_stall_o
`endif
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam int unsigned NxtW = RETRY_W + 1;

    sched_state_e       state_q, state_d;
    logic               stage_vld_q;
    logic [TAG_W-1:0]   stage_tag_q;
    logic [RETRY_W-1:0] stage_retry_q;
    logic               flt_vld_q;
    logic [TAG_W-1:0]   flt_tag_q;

    logic [CntW-1:0]    fifo_count;
    replay_ent_t        fifo_head, push_ent;
    logic               fifo_empty;

    logic               replay_go, new_rdy, new_go, iss_en;
    logic [TAG_W-1:0]   iss_tag;
    logic [RETRY_W-1:0] iss_retry;
    logic [NxtW-1:0]    retry_nxt;
    logic               miss_take, push, fault;

    // Slot arbitration: mex probe beats replay head beats new op; flush blocks any issue.
    always_comb begin
        replay_go = (state_q == REPLAY) & ~bus_io.mex_req & ~fifo_empty & ~bus_io.except;
        new_rdy   = (state_q == RUN) & ~bus_io.mex_req & ~bus_io.except &
                    (fifo_count <= CntW'(DEPTH - 2));
        new_go    = bus_io.new_vld & new_rdy;
        iss_en    = replay_go | new_go;
        iss_tag   = '0;
        iss_retry = '0;
        if (replay_go) begin
            iss_tag   = fifo_head.tag;
            iss_retry = fifo_head.retry_cnt;
        end else if (new_go) begin
            iss_tag   = bus_io.new_tag;
        end
    end

    // Miss capture: retry count is widened so the increment cannot wrap before the limit test.
    always_comb begin
        retry_nxt          = NxtW'(stage_retry_q) + NxtW'(1);
        miss_take          = bus_io.miss_vld & stage_vld_q & ~bus_io.except;
        fault              = miss_take & (retry_nxt > NxtW'(MAX_RETRY));
        push               = miss_take & ~fault;
        push_ent.tag       = stage_tag_q;
        push_ent.retry_cnt = retry_nxt[RETRY_W-1:0];
    end

    // Next-state logic: hold new issue while a walk is pending, replay after the fill.
    always_comb begin
        state_d = state_q;
        if (bus_io.except) begin
            state_d = RUN;
        end else begin
            unique case (state_q)
                RUN:     if (push) state_d = WAIT;
                WAIT:    if (bus_io.fill_done) state_d = REPLAY;
                REPLAY: begin
                    if (push) begin
                        state_d = WAIT;
                    end else if (fifo_empty || (replay_go && fifo_count == CntW'(1))) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Issue pipe stage: remembers what went out last cycle so a miss can be attributed to it.
    always_ff @(posedge clk) begin
        if (rst || bus_io.except) begin
            stage_vld_q   <= 1'b0;
            stage_tag_q   <= '0;
            stage_retry_q <= '0;
        end else begin
            stage_vld_q   <= iss_en;
            stage_tag_q   <= iss_tag;
            stage_retry_q <= iss_retry;
        end
    end

    // Fault pulse, one cycle after the miss that exhausted the retries.
    always_ff @(posedge clk) begin
        if (rst) begin
            flt_vld_q <= 1'b0;
            flt_tag_q <= '0;
        end else begin
            flt_vld_q <= fault;
            if (fault) flt_tag_q <= stage_tag_q;
        end
    end

    saddr_replay_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_ent_i (push_ent),
        .pop_i      (replay_go),
        .flush_i    (bus_io.except),
        .count_o    (fifo_count),
        .head_o     (fifo_head),
        .empty_o    (fifo_empty)
    );

    assign bus_io.new_rdy    = new_rdy;
    assign bus_io.mex_gnt    = bus_io.mex_req;
    assign bus_io.iss_en     = iss_en;
    assign bus_io.iss_tag    = iss_tag;
    assign bus_io.iss_replay = replay_go;
    assign bus_io.flt_vld    = flt_vld_q;
    assign bus_io.flt_tag    = flt_tag_q;

`ifdef SADDR_SCHED_PERF_EN
    logic [31:0] perf_miss_q, perf_stall_q;

    // Free-running counters; only reset clears them, a flush does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_miss_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (push) perf_miss_q <= perf_miss_q + 32'd1;
            if (bus_io.new_vld && !new_rdy) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_miss_o  = perf_miss_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_saddr_issue_sched.sv
// Bench for saddr_issue_sched: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based model of the scheduling rules.
module tb_saddr_issue_sched;
    import saddr_sched_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    saddr_issue_sched_if bus_if ();

`ifdef SADDR_SCHED_PERF_EN
    logic [31:0] perf_miss, perf_stall;
`endif

    saddr_issue_sched #(
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus_io       (bus_if)
`ifdef SADDR_SCHED_PERF_EN
        ,
        .perf_miss_o  (perf_miss),
        .perf_stall_o (perf_stall)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: list of ops awaiting replay, a mode, and the op issued last cycle.
    typedef struct {
        logic [TAG_W-1:0] tag;
        int               retry;
    } m_ent_t;

    m_ent_t           mq [$];
    int               m_mode;        // 0 running, 1 waiting for fill, 2 replaying
    bit               m_stg_v;
    logic [TAG_W-1:0] m_stg_tag;
    int               m_stg_retry;
    bit               m_flt_v;
    logic [TAG_W-1:0] m_flt_tag;
    int unsigned      m_miss, m_stall;
    bit               e_rep, e_rdy, e_en, took, m_push;
    logic [TAG_W-1:0] e_tag;
    int               e_retry, n_retry;

    // Per-cycle compare and model advance, sampled mid low phase after inputs settle.
    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                mq.delete();
                m_mode  = 0;
                m_stg_v = 1'b0;
                m_flt_v = 1'b0;
                m_miss  = 0;
                m_stall = 0;
            end else begin
                e_rep = (m_mode == 2) && !bus_if.mex_req && (mq.size() > 0) && !bus_if.except;
                e_rdy = (m_mode == 0) && !bus_if.mex_req && !bus_if.except &&
                        (mq.size() <= DEPTH - 2);
                e_en  = e_rep || (bus_if.new_vld && e_rdy);
                e_tag = e_rep ? mq[0].tag : (e_en ? bus_if.new_tag : '0);
                e_retry = e_rep ? mq[0].retry : 0;

                chk("m_new_rdy", 32'(bus_if.new_rdy), 32'(e_rdy));
                chk("m_mex_gnt", 32'(bus_if.mex_gnt), 32'(bus_if.mex_req));
                chk("m_iss_en", 32'(bus_if.iss_en), 32'(e_en));
                chk("m_iss_replay", 32'(bus_if.iss_replay), 32'(e_rep));
                if (e_en) chk("m_iss_tag", 32'(bus_if.iss_tag), 32'(e_tag));
                chk("m_flt_vld", 32'(bus_if.flt_vld), 32'(m_flt_v));
                if (m_flt_v) chk("m_flt_tag", 32'(bus_if.flt_tag), 32'(m_flt_tag));
`ifdef SADDR_SCHED_PERF_EN
                chk("m_perf_miss", perf_miss, m_miss);
                chk("m_perf_stall", perf_stall, m_stall);
`endif
                took    = bus_if.miss_vld && m_stg_v && !bus_if.except;
                n_retry = m_stg_retry + 1;
                m_push  = took && (n_retry <= MAX_RETRY);
                m_flt_v = took && (n_retry > MAX_RETRY);
                if (m_flt_v) m_flt_tag = m_stg_tag;
                if (m_push) m_miss++;
                if (bus_if.new_vld && !e_rdy) m_stall++;

                if (bus_if.except) begin
                    mq.delete();
                    m_mode  = 0;
                    m_stg_v = 1'b0;
                end else begin
                    if (e_rep) void'(mq.pop_front());
                    if (m_push) mq.push_back('{tag: m_stg_tag, retry: n_retry});
                    if (m_mode == 0 && m_push) m_mode = 1;
                    else if (m_mode == 1 && bus_if.fill_done) m_mode = 2;
                    else if (m_mode == 2 && m_push) m_mode = 1;
                    else if (m_mode == 2 && mq.size() == 0) m_mode = 0;
                    m_stg_v     = e_en;
                    m_stg_tag   = e_tag;
                    m_stg_retry = e_retry;
                end
            end
        end
    end

    task automatic drive(input bit nv, input int tag, input bit mex, input bit miss,
                         input bit fill, input bit exc);
        @(negedge clk);
        bus_if.new_vld   = nv;
        bus_if.new_tag   = TAG_W'(tag);
        bus_if.mex_req   = mex;
        bus_if.miss_vld  = miss;
        bus_if.fill_done = fill;
        bus_if.except    = exc;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : stim
        bus_if.new_vld   = 1'b0;
        bus_if.new_tag   = '0;
        bus_if.mex_req   = 1'b0;
        bus_if.miss_vld  = 1'b0;
        bus_if.fill_done = 1'b0;
        bus_if.except    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_new_rdy", 32'(bus_if.new_rdy), 32'd1);
        chk("rst_iss_en", 32'(bus_if.iss_en), 32'd0);
        chk("rst_mex_gnt", 32'(bus_if.mex_gnt), 32'd0);
        chk("rst_flt_vld", 32'(bus_if.flt_vld), 32'd0);
        chk("rst_iss_tag", 32'(bus_if.iss_tag), 32'd0);

        // Plain issue of three new ops.
        for (int t = 1; t <= 3; t++) begin
            drive(1'b1, t, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("t1_iss_en", 32'(bus_if.iss_en), 32'd1);
            chk("t1_iss_tag", 32'(bus_if.iss_tag), 32'(t));
            chk("t1_iss_replay", 32'(bus_if.iss_replay), 32'd0);
        end

        // Single miss, walk, replay.
        drive(1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_iss_tag", 32'(bus_if.iss_tag), 32'd5);
        drive(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("t2_held", 32'(bus_if.new_rdy), 32'd0);
        repeat (9) idle();
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t2_fill_no_iss", 32'(bus_if.iss_en), 32'd0);
        idle();
        chk("t2_replay", 32'(bus_if.iss_replay), 32'd1);
        chk("t2_replay_tag", 32'(bus_if.iss_tag), 32'd5);
        idle();
        chk("t2_back_to_run", 32'(bus_if.new_rdy), 32'd1);

        // Two back-to-back misses replay in order.
        drive(1'b1, 6, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 7, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t3_second_issue", 32'(bus_if.iss_tag), 32'd7);
        drive(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("t3_held", 32'(bus_if.new_rdy), 32'd0);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("t3_replay_a", 32'(bus_if.iss_tag), 32'd6);
        idle();
        chk("t3_replay_b", 32'(bus_if.iss_tag), 32'd7);
        chk("t3_replay_b_flag", 32'(bus_if.iss_replay), 32'd1);
        idle();
        chk("t3_back_to_run", 32'(bus_if.new_rdy), 32'd1);

        // Miss handler takes the replay slot for one cycle.
        drive(1'b1, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t4_mex_gnt", 32'(bus_if.mex_gnt), 32'd1);
        chk("t4_no_iss", 32'(bus_if.iss_en), 32'd0);
        idle();
        chk("t4_replay", 32'(bus_if.iss_replay), 32'd1);
        chk("t4_replay_tag", 32'(bus_if.iss_tag), 32'd8);

        // Retry exhaustion: fourth miss of tag 9 faults.
        drive(1'b1, 9, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            idle();
            drive(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
            idle();
            chk("t5_replay_tag", 32'(bus_if.iss_tag), 32'd9);
            drive(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        idle();
        chk("t5_flt_vld", 32'(bus_if.flt_vld), 32'd1);
        chk("t5_flt_tag", 32'(bus_if.flt_tag), 32'd9);
        chk("t5_run", 32'(bus_if.new_rdy), 32'd1);
        idle();
        chk("t5_flt_pulse", 32'(bus_if.flt_vld), 32'd0);

        // Flush while waiting with two entries held.
        drive(1'b1, 10, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 11, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("t6_held", 32'(bus_if.new_rdy), 32'd0);
        drive(1'b1, 12, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_exc_rdy", 32'(bus_if.new_rdy), 32'd0);
        chk("t6_exc_iss", 32'(bus_if.iss_en), 32'd0);
        idle();
        chk("t6_after_rdy", 32'(bus_if.new_rdy), 32'd1);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("t6_fill_ignored", 32'(bus_if.iss_en), 32'd0);
        chk("t6_still_run", 32'(bus_if.new_rdy), 32'd1);
`ifdef SADDR_SCHED_PERF_EN
        chk("t6_perf_miss", perf_miss, 32'd9);
`endif
        // Flush in the running state blocks the offered op.
        drive(1'b1, 13, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t6_run_exc_iss", 32'(bus_if.iss_en), 32'd0);
        chk("t6_run_exc_mex", 32'(bus_if.mex_gnt), 32'd1);

        // Random traffic, checked by the monitor every cycle.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 511)),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 59) == 0));
        end
        idle();
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
